toast_regfile: RTL and testbench



---
 rtl/toast_regfile.sv | 92 +++++++++
 tb/tb_toast_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/toast_regfile.sv
// rtl/toast_regfile.sv - RV32I integer register file with post-reset clear sequencer.
// Optional same-cycle WB->ID write-through is enabled by defining TOAST_RF_BYPASS_EN.
module toast_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] WB_rd_addr_i,
   input  logic [DATA_WIDTH-1:0] WB_rd_wr_data_i,
   input  logic                  WB_rd_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] ID_rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] ID_rs2_addr_i,
   output logic [DATA_WIDTH-1:0] ID_rs1_data_o,
   output logic [DATA_WIDTH-1:0] ID_rs2_data_o,
   output logic                  RF_init_busy_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_idx;
   logic                  busy;
   logic                  wr_fire;

   // No reset on the array so it maps onto distributed RAM.
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   assign wr_fire = WB_rd_wr_en_i && (WB_rd_addr_i != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_CLEAR;
         clr_idx <= FIRST_IDX;
         busy    <= 1'b1;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_idx <= clr_idx + 1'b1;
               if (clr_idx == LAST_IDX) begin
                  state <= S_RUN;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Single write port shared by the clear sequencer and writeback; x0 is never touched.
   always_ff @(posedge clk_i) begin
      if (state == S_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (wr_fire) begin
         mem[WB_rd_addr_i] <= WB_rd_wr_data_i;
      end
   end

   always_comb begin
      ID_rs1_data_o = '0;
      if (!busy && ID_rs1_addr_i != '0) begin
         ID_rs1_data_o = mem[ID_rs1_addr_i];
`ifdef TOAST_RF_BYPASS_EN
         if (wr_fire && WB_rd_addr_i == ID_rs1_addr_i) begin
            ID_rs1_data_o = WB_rd_wr_data_i;
         end
`endif
      end
   end

   always_comb begin
      ID_rs2_data_o = '0;
      if (!busy && ID_rs2_addr_i != '0) begin
         ID_rs2_data_o = mem[ID_rs2_addr_i];
`ifdef TOAST_RF_BYPASS_EN
         if (wr_fire && WB_rd_addr_i == ID_rs2_addr_i) begin
            ID_rs2_data_o = WB_rd_wr_data_i;
         end
`endif
      end
   end

   assign RF_init_busy_o = busy;

endmodule

// File: tb/tb_toast_regfile.sv
// tb/tb_toast_regfile.sv - directed vector bench for toast_regfile.
// Expectations follow TOAST_RF_BYPASS_EN when the macro is defined for the build.
module tb_toast_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef TOAST_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   toast_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .WB_rd_addr_i    (wb_addr),
      .WB_rd_wr_data_i (wb_data),
      .WB_rd_wr_en_i   (wb_en),
      .ID_rs1_addr_i   (rs1_addr),
      .ID_rs2_addr_i   (rs2_addr),
      .ID_rs1_data_o   (rs1_data),
      .ID_rs2_data_o   (rs2_data),
      .RF_init_busy_o  (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   // Counts rising edges after reset release until busy drops; returns 999 on timeout.
   task automatic count_clear(output int n);
      n = 999;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (busy) begin
            check("read_during_clear_rs1", rs1_data, 32'h0);
            check("read_during_clear_rs2", rs2_data, 32'h0);
         end
         if (!busy) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;

      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5,
                  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
      vecs[1] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7,
                  32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0};
      vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
      vecs[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0};
      vecs[6] = '{1'b1, 5'd9, 32'h0000FFFF, 5'd9, 5'd3,
                  BYP ? 32'h0000FFFF : 32'h0, 32'h0};
      vecs[7] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 32'h0000FFFF, 32'hA5A5A5A5};
      vecs[8] = '{1'b1, 5'd7, 32'h11111111, 5'd9, 5'd7,
                  32'h0000FFFF, BYP ? 32'h11111111 : 32'hA5A5A5A5};
      vecs[9] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h11111111, 32'h11111111};

      // Reset state; a WB write of x3 is held through the whole clear.
      #1 rst = 1'b1;
      rs1_addr = 5'd3;
      rs2_addr = 5'd5;
      wb_en = 1'b1;
      wb_addr = 5'd3;
      wb_data = 32'h1;
      #1;
      check("reset_busy", {31'b0, busy}, 32'h1);
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_rs2", rs2_data, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      count_clear(n);
      wb_en = 1'b0;
      check("busy_edges", n, 31);

      for (int i = 1; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(i);
         #1;
         check("cleared_rs1", rs1_data, 32'h0);
         check("cleared_rs2", rs2_data, 32'h0);
      end

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         wb_en = vecs[i].we;
         wb_addr = vecs[i].wa;
         wb_data = vecs[i].wd;
         rs1_addr = vecs[i].a1;
         rs2_addr = vecs[i].a2;
         #1;
         check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
         check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
      end
      @(negedge clk);
      wb_en = 1'b0;

      // Reset pulse after a run, then again 10 edges into the clear.
      rs1_addr = 5'd9;
      rs2_addr = 5'd7;
      rst = 1'b1;
      #1;
      check("async_busy", {31'b0, busy}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("busy_at_clear10", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("busy_mid_reset", {31'b0, busy}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      count_clear(n);
      check("busy_edges_restart", n, 31);
      #1;
      check("x9_after_restart", rs1_data, 32'h0);
      check("x7_after_restart", rs2_data, 32'h0);

      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         wb_en = 1'b1;
         wb_addr = 5'(i);
         wb_data = 32'(i);
      end
      @(negedge clk);
      wb_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check($sformatf("idx_rs1_x%0d", i), rs1_data, 32'(i));
         check($sformatf("idx_rs2_x%0d", 31 - i), rs2_data, 32'(31 - i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
